// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiplier / restoring divider taking WIDTH cycles per operation.
// Define MCYCLE_DIV_EN to build the divider; without it, divides complete on time with zero results.
module mcycle_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic [3:0]       WA3In,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       MCycleWA3
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      count_r;
  logic               is_div_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               neg_lo_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   result1_r;
  logic [WIDTH-1:0]   result2_r;
  logic [3:0]         wa3_r;
`ifdef MCYCLE_DIV_EN
  logic               neg_hi_r;
  logic               div0_r;
  logic [WIDTH-1:0]   dividend_r;
  logic [WIDTH:0]     rem_wide_s;
  logic [WIDTH-1:0]   sub_s;
  logic [2*WIDTH-1:0] div_nxt_s;
`endif

  logic               s1_s;
  logic               s2_s;
  logic [WIDTH-1:0]   abs1_s;
  logic [WIDTH-1:0]   abs2_s;
  logic [WIDTH:0]     add_s;
  logic [2*WIDTH-1:0] mul_nxt_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] step_nxt_s;
  logic [WIDTH-1:0]   res1_s;
  logic [WIDTH-1:0]   res2_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Operand signs and magnitudes captured on acceptance
  always_comb begin
    s1_s = MCycleOp[1] & Operand1[WIDTH-1];
    s2_s = MCycleOp[1] & Operand2[WIDTH-1];
    if (s1_s) begin
      abs1_s = neg_w(Operand1);
    end else begin
      abs1_s = Operand1;
    end
    if (s2_s) begin
      abs2_s = neg_w(Operand2);
    end else begin
      abs2_s = Operand2;
    end
  end

  // One iteration step, plus the sign fix-up used when the last step completes
  always_comb begin
    // Multiplier bits shift out of the low half as product bits shift in from the top
    add_s     = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r & {WIDTH{acc_r[0]}}};
    mul_nxt_s = {add_s, acc_r[WIDTH-1:1]};
    if (neg_lo_r) begin
      prod_s = neg_2w(mul_nxt_s);
    end else begin
      prod_s = mul_nxt_s;
    end
`ifdef MCYCLE_DIV_EN
    // Shifted partial remainder can reach WIDTH+1 bits before the trial subtract
    rem_wide_s = acc_r[2*WIDTH-1:WIDTH-1];
    sub_s      = rem_wide_s[WIDTH-1:0] - mcand_r;
    if (rem_wide_s >= {1'b0, mcand_r}) begin
      div_nxt_s = {sub_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      div_nxt_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end
    if (is_div_r) begin
      step_nxt_s = div_nxt_s;
      if (div0_r) begin
        res1_s = {WIDTH{1'b1}};
        res2_s = dividend_r;
      end else begin
        // MIN / -1 falls out naturally: magnitude 2^(WIDTH-1), positive sign, zero remainder
        res1_s = neg_lo_r ? neg_w(div_nxt_s[WIDTH-1:0]) : div_nxt_s[WIDTH-1:0];
        res2_s = neg_hi_r ? neg_w(div_nxt_s[2*WIDTH-1:WIDTH]) : div_nxt_s[2*WIDTH-1:WIDTH];
      end
    end else begin
      step_nxt_s = mul_nxt_s;
      res1_s     = prod_s[WIDTH-1:0];
      res2_s     = prod_s[2*WIDTH-1:WIDTH];
    end
`else
    step_nxt_s = mul_nxt_s;
    if (is_div_r) begin
      res1_s = {WIDTH{1'b0}};
      res2_s = {WIDTH{1'b0}};
    end else begin
      res1_s = prod_s[WIDTH-1:0];
      res2_s = prod_s[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // Control FSM, operand capture, iteration state and registered outputs
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r    <= S_IDLE;
      count_r    <= ZERO_CNT;
      is_div_r   <= 1'b0;
      mcand_r    <= {WIDTH{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      neg_lo_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result1_r  <= {WIDTH{1'b0}};
      result2_r  <= {WIDTH{1'b0}};
      wa3_r      <= 4'd0;
`ifdef MCYCLE_DIV_EN
      neg_hi_r   <= 1'b0;
      div0_r     <= 1'b0;
      dividend_r <= {WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          done_r <= 1'b0;
          if (Start) begin
            state_r  <= S_RUN;
            busy_r   <= 1'b1;
            count_r  <= ZERO_CNT;
            is_div_r <= MCycleOp[0];
            wa3_r    <= WA3In;
            neg_lo_r <= s1_s ^ s2_s;
`ifdef MCYCLE_DIV_EN
            neg_hi_r   <= s1_s;
            div0_r     <= (Operand2 == {WIDTH{1'b0}});
            dividend_r <= Operand1;
            if (MCycleOp[0]) begin
              mcand_r <= abs2_s;
              acc_r   <= {{WIDTH{1'b0}}, abs1_s};
            end else begin
              mcand_r <= abs1_s;
              acc_r   <= {{WIDTH{1'b0}}, abs2_s};
            end
`else
            mcand_r <= abs1_s;
            acc_r   <= {{WIDTH{1'b0}}, abs2_s};
`endif
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        end
        S_RUN: begin
          acc_r <= step_nxt_s;
          if (count_r == LAST_CNT) begin
            state_r   <= S_DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            count_r   <= ZERO_CNT;
            result1_r <= res1_s;
            result2_r <= res2_s;
          end else begin
            count_r <= count_r + ONE_CNT;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          count_r <= ZERO_CNT;
        end
      endcase
    end
  end

  assign Busy      = busy_r;
  assign Done      = done_r;
  assign Result1   = result1_r;
  assign Result2   = result2_r;
  assign MCycleWA3 = wa3_r;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed plus randomized self-checking bench for mcycle_unit (WIDTH=32),
// compared against an arithmetic reference model; follows MCYCLE_DIV_EN like the design.
module tb_mcycle_unit;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  MCycleOp = 2'd0;
  logic [31:0] Operand1 = 32'd0;
  logic [31:0] Operand2 = 32'd0;
  logic [3:0]  WA3In = 4'd0;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        Done;
  logic [3:0]  MCycleWA3;

  int n_cmp = 0;
  int n_mis = 0;

  mcycle_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2), .WA3In(WA3In),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done),
    .MCycleWA3(MCycleWA3)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r1, output logic [31:0] r2);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    if (!op[0]) begin
      if (op[1]) p = 64'(sa * sb);
      else       p = {32'd0, a} * {32'd0, b};
      r1 = p[31:0];
      r2 = p[63:32];
    end else begin
`ifdef MCYCLE_DIV_EN
      if (b == 32'd0) begin
        r1 = 32'hFFFF_FFFF;
        r2 = a;
      end else if (op[1]) begin
        q  = 64'(sa / sb);
        r  = 64'(sa % sb);
        r1 = q[31:0];
        r2 = r[31:0];
      end else begin
        r1 = a / b;
        r2 = a % b;
      end
`else
      r1 = 32'd0;
      r2 = 32'd0;
`endif
    end
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(5, 0))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(20, 0));
      4: return 32'hFFFF_FFFF - 32'($urandom_range(20, 0));
      default: return $urandom;
    endcase
  endfunction

  // Entered at a negedge; leaves at a negedge so the next call can start back-to-back
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] wa, input bit inject, input int gap);
    logic [31:0] e1;
    logic [31:0] e2;
    int busy_n = 0;
    int done_seen = 0;
    int wa_bad = 0;
    int overlap = 0;
    ref_model(op, a, b, e1, e2);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b; WA3In = wa;
    @(posedge CLK); #1;
    Start = 1'b0;
    MCycleOp = 2'($urandom); Operand1 = $urandom; Operand2 = $urandom; WA3In = 4'($urandom);
    for (int i = 1; i <= 40 && done_seen == 0; i++) begin
      @(negedge CLK);
      if (Busy && Done) overlap = 1;
      if (MCycleWA3 !== wa) wa_bad = 1;
      if (Done) done_seen = 1;
      else if (Busy) busy_n++;
      if (inject && i == 7) begin
        Start = 1'b1; MCycleOp = 2'($urandom); Operand1 = $urandom; Operand2 = $urandom;
        WA3In = 4'($urandom);
      end else begin
        Start = 1'b0;
      end
    end
    check_val("done_seen", 32'(done_seen), 32'd1);
    check_val("busy_cycles", 32'(busy_n), 32'd32);
    check_val("wa3_stable", 32'(wa_bad), 32'd0);
    check_val("busy_done_overlap", 32'(overlap), 32'd0);
    check_val("result1", Result1, e1);
    check_val("result2", Result2, e2);
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK);
      check_val("idle_done", {31'd0, Done}, 32'd0);
      check_val("idle_busy", {31'd0, Busy}, 32'd0);
      check_val("hold_result1", Result1, e1);
      check_val("hold_result2", Result2, e2);
      check_val("hold_wa3", {28'd0, MCycleWA3}, {28'd0, wa});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_busy", {31'd0, Busy}, 32'd0);
    check_val("rst_done", {31'd0, Done}, 32'd0);
    check_val("rst_result1", Result1, 32'd0);
    check_val("rst_result2", Result2, 32'd0);
    check_val("rst_wa3", {28'd0, MCycleWA3}, 32'd0);
    RESETn = 1'b1;
    @(negedge CLK);

    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 4'd5, 1'b0, 2);
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 4'd3, 1'b0, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 4'd9, 1'b0, 1);
    run_op(2'b01, 32'd100, 32'd0, 4'd1, 1'b0, 1);
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 4'd14, 1'b0, 1);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd0, 4'd6, 1'b0, 0);
    run_op(2'b00, 32'd1234, 32'd5678, 4'd7, 1'b1, 1);

    // Abort an operation with an asynchronous reset in the middle of RUN
    Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd99; Operand2 = 32'd77; WA3In = 4'd12;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) @(negedge CLK);
    check_val("pre_abort_busy", {31'd0, Busy}, 32'd1);
    #2 RESETn = 1'b0;
    #1;
    check_val("abort_busy", {31'd0, Busy}, 32'd0);
    check_val("abort_done", {31'd0, Done}, 32'd0);
    check_val("abort_result1", Result1, 32'd0);
    check_val("abort_result2", Result2, 32'd0);
    check_val("abort_wa3", {28'd0, MCycleWA3}, 32'd0);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    check_val("post_abort_busy", {31'd0, Busy}, 32'd0);
    run_op(2'b00, 32'd6, 32'd7, 4'd2, 1'b0, 1);

    for (int k = 0; k < 40; k++) begin
      run_op(2'($urandom), pick_val(), pick_val(), 4'($urandom), 1'($urandom),
             $urandom_range(2, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
